k12a_io_uart: RTL

- I/O-bus responder for the k12a core. Services `in`/`out` accesses (io_load/io_store with a 3-bit port number from inst[2:0]) and bridges them to an 8N1 serial line.
- Contains a 4-entry TX FIFO, a TX shifter, a single-byte RX holding register and a programmable baud divisor.
- Sits on the 8-bit data bus beside memory, as the peripheral end of the core's I/O port interface.

---
 rtl/k12a_io_uart_pkg.sv | 34 +++
 rtl/k12a_uart_fifo.sv | 48 ++++
 rtl/k12a_io_uart.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/k12a_io_uart_pkg.sv
// Shared types and constants for the k12a I/O-port UART.
package k12a_io_uart_pkg;

    typedef enum logic [1:0] {
        UART_TX_IDLE,
        UART_TX_START,
        UART_TX_DATA,
        UART_TX_STOP
    } uart_tx_state_t;

    typedef enum logic [2:0] {
        UART_RX_IDLE,
        UART_RX_START,
        UART_RX_DATA,
        UART_RX_STOP,
        UART_RX_WAIT_IDLE
    } uart_rx_state_t;

    // Register offsets within the block (io_addr[1:0])
    localparam logic [1:0] UART_REG_DATA   = 2'h0;
    localparam logic [1:0] UART_REG_STATUS = 2'h1;
    localparam logic [1:0] UART_REG_DIVLO  = 2'h2;
    localparam logic [1:0] UART_REG_DIVHI  = 2'h3;

    // STATUS register bit positions
    localparam int UART_STATUS_TX_FULL   = 0;
    localparam int UART_STATUS_TX_EMPTY  = 1;
    localparam int UART_STATUS_TX_BUSY   = 2;
    localparam int UART_STATUS_RX_VALID  = 3;
    localparam int UART_STATUS_RX_OVR    = 4;
    localparam int UART_STATUS_RX_FERR   = 5;
    localparam int UART_STATUS_TX_IRQ_EN = 6;

endpackage

// File: rtl/k12a_uart_fifo.sv
// Synchronous circular FIFO; pointers carry one extra wrap bit so full and
// empty are distinguished without a separate counter.
module k12a_uart_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic [WIDTH-1:0]    mem [DEPTH];
    logic                do_push;
    logic                do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr[DEPTH_LOG2-1:0]];

    // Advance pointers; a push while full is silently dropped
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
    end

endmodule

// File: rtl/k12a_io_uart.sv
// k12a I/O-bus UART: register file on the core's port bus, TX FIFO + shifter,
// single-byte RX holding register, 8N1 framing with a programmable divisor.
// Handshake: the core presents io_addr with io_load or io_store for one cycle;
// read data is combinational in that cycle and side effects land on its edge.
module k12a_io_uart
    import k12a_io_uart_pkg::*;
#(
    parameter logic [2:0]  PORT_BASE       = 3'h0,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd103,
    parameter int          FIFO_DEPTH_LOG2 = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [2:0] io_addr,
    input  logic       io_load,
    input  logic       io_store,
    input  logic [7:0] data_bus_in,
    output logic [7:0] data_bus_out,
    output logic       data_bus_out_en,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic       irq
);

    logic           selected, wr_en, rd_en, rd_data_pop;
    logic [1:0]     offset;
    logic [15:0]    divisor;
    logic           tx_irq_en, rx_valid, rx_overrun, rx_frame_err;
    logic [7:0]     rx_data, status, read_mux;
    logic           push, pop, fifo_full, fifo_empty, tx_busy, tx_empty;
    logic [7:0]     fifo_dout;
    uart_tx_state_t tx_state;
    logic [7:0]     tx_shift;
    logic [2:0]     tx_bit_cnt;
    logic [15:0]    tx_cnt;
    uart_rx_state_t rx_state;
    logic [7:0]     rx_shift;
    logic [2:0]     rx_bit_cnt;
    logic [15:0]    rx_cnt;
    logic           rx_s1, rx_s2, rx_prev, rx_deliver, rx_ferr_set;

    // Decode: a store wins over a simultaneous load
    assign selected    = (io_addr[2] == PORT_BASE[2]);
    assign offset      = io_addr[1:0];
    assign wr_en       = io_store & selected;
    assign rd_en       = io_load & selected & ~io_store;
    assign rd_data_pop = rd_en && (offset == UART_REG_DATA);

    assign push     = wr_en && (offset == UART_REG_DATA);
    assign pop      = !fifo_empty && ((tx_state == UART_TX_IDLE) ||
                      (tx_state == UART_TX_STOP && tx_cnt == 16'd0));
    assign tx_busy  = (tx_state != UART_TX_IDLE);
    assign tx_empty = fifo_empty && !tx_busy;

    assign rx_deliver  = (rx_state == UART_RX_STOP) && (rx_cnt == 16'd0) && rx_s2;
    assign rx_ferr_set = (rx_state == UART_RX_STOP) && (rx_cnt == 16'd0) && !rx_s2;

    assign irq             = rx_valid | (tx_empty & tx_irq_en);
    assign data_bus_out_en = io_load & selected;
    assign data_bus_out    = selected ? read_mux : 8'h00;

    k12a_uart_fifo #(.WIDTH(8), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (data_bus_in),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Assemble STATUS and select the read data for the addressed register
    always_comb begin
        status = 8'h00;
        status[UART_STATUS_TX_FULL]   = fifo_full;
        status[UART_STATUS_TX_EMPTY]  = tx_empty;
        status[UART_STATUS_TX_BUSY]   = tx_busy;
        status[UART_STATUS_RX_VALID]  = rx_valid;
        status[UART_STATUS_RX_OVR]    = rx_overrun;
        status[UART_STATUS_RX_FERR]   = rx_frame_err;
        status[UART_STATUS_TX_IRQ_EN] = tx_irq_en;
        case (offset)
            UART_REG_DATA:   read_mux = rx_data;
            UART_REG_STATUS: read_mux = status;
            UART_REG_DIVLO:  read_mux = divisor[7:0];
            default:         read_mux = divisor[15:8];
        endcase
    end

    // Control/status registers and the RX holding register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            divisor      <= DEFAULT_DIVISOR;
            tx_irq_en    <= 1'b0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_data      <= 8'h00;
        end else begin
            if (wr_en && offset == UART_REG_DIVLO) divisor[7:0]  <= data_bus_in;
            if (wr_en && offset == UART_REG_DIVHI) divisor[15:8] <= data_bus_in;
            if (wr_en && offset == UART_REG_STATUS) begin
                tx_irq_en <= data_bus_in[UART_STATUS_TX_IRQ_EN];
                if (data_bus_in[UART_STATUS_RX_OVR])  rx_overrun   <= 1'b0;
                if (data_bus_in[UART_STATUS_RX_FERR]) rx_frame_err <= 1'b0;
            end
            if (rd_data_pop) rx_valid <= 1'b0;
            // A new byte overrides a same-edge read; overrun only if unread
            if (rx_deliver) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
                if (rx_valid && !rd_data_pop) rx_overrun <= 1'b1;
            end
            if (rx_ferr_set) rx_frame_err <= 1'b1;
        end
    end

    // TX FSM: start bit, 8 data bits LSB-first, stop bit; frames chain with no gap
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_state   <= UART_TX_IDLE;
            tx_shift   <= 8'h00;
            tx_bit_cnt <= 3'd0;
            tx_cnt     <= 16'd0;
            uart_tx    <= 1'b1;
        end else begin
            case (tx_state)
                UART_TX_IDLE: begin
                    if (!fifo_empty) begin
                        tx_shift <= fifo_dout;
                        tx_cnt   <= divisor;
                        uart_tx  <= 1'b0;
                        tx_state <= UART_TX_START;
                    end
                end
                UART_TX_START: begin
                    if (tx_cnt == 16'd0) begin
                        tx_cnt     <= divisor;
                        tx_bit_cnt <= 3'd0;
                        uart_tx    <= tx_shift[0];
                        tx_state   <= UART_TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                UART_TX_DATA: begin
                    if (tx_cnt == 16'd0) begin
                        tx_cnt <= divisor;
                        if (tx_bit_cnt == 3'd7) begin
                            uart_tx  <= 1'b1;
                            tx_state <= UART_TX_STOP;
                        end else begin
                            tx_shift   <= {1'b0, tx_shift[7:1]};
                            uart_tx    <= tx_shift[1];
                            tx_bit_cnt <= tx_bit_cnt + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                default: begin
                    if (tx_cnt == 16'd0) begin
                        if (!fifo_empty) begin
                            tx_shift <= fifo_dout;
                            tx_cnt   <= divisor;
                            uart_tx  <= 1'b0;
                            tx_state <= UART_TX_START;
                        end else begin
                            tx_state <= UART_TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // RX FSM: mid-start-bit check rejects glitches, then samples each bit centre
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_state   <= UART_RX_IDLE;
            rx_shift   <= 8'h00;
            rx_bit_cnt <= 3'd0;
            rx_cnt     <= 16'd0;
        end else begin
            case (rx_state)
                UART_RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_cnt   <= divisor >> 1;
                        rx_state <= UART_RX_START;
                    end
                end
                UART_RX_START: begin
                    if (rx_cnt == 16'd0) begin
                        rx_cnt     <= divisor;
                        rx_bit_cnt <= 3'd0;
                        rx_state   <= rx_s2 ? UART_RX_IDLE : UART_RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                UART_RX_DATA: begin
                    if (rx_cnt == 16'd0) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_cnt   <= divisor;
                        if (rx_bit_cnt == 3'd7) rx_state <= UART_RX_STOP;
                        else                    rx_bit_cnt <= rx_bit_cnt + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                UART_RX_STOP: begin
                    if (rx_cnt == 16'd0) rx_state <= rx_s2 ? UART_RX_IDLE : UART_RX_WAIT_IDLE;
                    else                 rx_cnt   <= rx_cnt - 16'd1;
                end
                default: begin
                    if (rx_s2) rx_state <= UART_RX_IDLE;
                end
            endcase
        end
    end

endmodule
